// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared encodings for the execute stage.
//   - ALU operation codes (ex_alu_op) and result-group selects (ex_alu_sel)
//   - bus widths and the all-zero word
//   - divider FSM state encoding
package ex_stage_pkg;

  localparam int unsigned DataW    = 32;
  localparam int unsigned RegAddrW = 5;
  localparam int unsigned AluOpW   = 8;
  localparam int unsigned AluSelW  = 3;

  localparam logic [DataW-1:0] zero_word = '0;

  // Operation codes
  localparam logic [AluOpW-1:0] exe_and_op  = 8'h24;
  localparam logic [AluOpW-1:0] exe_or_op   = 8'h25;
  localparam logic [AluOpW-1:0] exe_xor_op  = 8'h26;
  localparam logic [AluOpW-1:0] exe_nor_op  = 8'h27;
  localparam logic [AluOpW-1:0] exe_sll_op  = 8'h7C;
  localparam logic [AluOpW-1:0] exe_srl_op  = 8'h02;
  localparam logic [AluOpW-1:0] exe_sra_op  = 8'h03;
  localparam logic [AluOpW-1:0] exe_add_op  = 8'h20;
  localparam logic [AluOpW-1:0] exe_addu_op = 8'h21;
  localparam logic [AluOpW-1:0] exe_sub_op  = 8'h22;
  localparam logic [AluOpW-1:0] exe_subu_op = 8'h23;
  localparam logic [AluOpW-1:0] exe_slt_op  = 8'h2A;
  localparam logic [AluOpW-1:0] exe_sltu_op = 8'h2B;
  localparam logic [AluOpW-1:0] exe_div_op  = 8'h1A;
  localparam logic [AluOpW-1:0] exe_divu_op = 8'h1B;

  // Result-group selects
  localparam logic [AluSelW-1:0] RES_NOP   = 3'b000;
  localparam logic [AluSelW-1:0] RES_LOGIC = 3'b001;
  localparam logic [AluSelW-1:0] RES_SHIFT = 3'b010;
  localparam logic [AluSelW-1:0] RES_ARITH = 3'b100;

  typedef enum logic [1:0] {
    DivIdle,
    DivBusy,
    DivByZero,
    DivDone
  } div_state_e;

endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX operand/control bus and EX/MEM result bus of the execute stage.
//   slave  : used by ex_stage (consumes ex_*/flush, drives em_*/stall_req)
//   master : used by the surrounding pipeline / testbench
interface ex_stage_if;
  import ex_stage_pkg::*;

  logic                flush;
  logic [AluOpW-1:0]   ex_alu_op;
  logic [AluSelW-1:0]  ex_alu_sel;
  logic [DataW-1:0]    ex_src1;
  logic [DataW-1:0]    ex_src2;
  logic [RegAddrW-1:0] ex_des_addr;
  logic                ex_des_exist;

  logic [DataW-1:0]    em_result;
  logic [RegAddrW-1:0] em_des_addr;
  logic                em_des_exist;
  logic [DataW-1:0]    em_hi;
  logic [DataW-1:0]    em_lo;
  logic                em_hilo_we;
  logic                stall_req;

  modport slave (
    input  flush, ex_alu_op, ex_alu_sel, ex_src1, ex_src2, ex_des_addr, ex_des_exist,
    output em_result, em_des_addr, em_des_exist, em_hi, em_lo, em_hilo_we, stall_req
  );

  modport master (
    output flush, ex_alu_op, ex_alu_sel, ex_src1, ex_src2, ex_des_addr, ex_des_exist,
    input  em_result, em_des_addr, em_des_exist, em_hi, em_lo, em_hilo_we, stall_req
  );

endinterface

// File: rtl/ex_stage_div_unit.sv
// div_unit: iterative restoring divider, one quotient bit per cycle.
//   clk, rst     : clock, synchronous active-high reset
//   flush_i      : abort any in-flight divide, return to idle
//   start_i      : DIV/DIVU present on the ID/EX inputs
//   signed_i     : 1 = DIV (signed), 0 = DIVU
//   src1_i/src2_i: dividend / divisor
//   stall_o      : hold upstream while the divide is in progress
//   hilo_we_o    : one-cycle HI/LO write strobe (DONE state)
//   hi_o / lo_o  : remainder / quotient, zero outside DONE
module div_unit
  import ex_stage_pkg::*;
#(
  parameter int unsigned DIV_STEPS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [DataW-1:0] src1_i,
  input  logic [DataW-1:0] src2_i,
  output logic             stall_o,
  output logic             hilo_we_o,
  output logic [DataW-1:0] hi_o,
  output logic [DataW-1:0] lo_o
);

  localparam int unsigned CntW = $clog2(DIV_STEPS);
  localparam logic [CntW-1:0] LastCnt = CntW'(DIV_STEPS - 1);

  div_state_e       state_q;
  logic [CntW-1:0]  cnt_q;
  logic [DataW-1:0] quo_q, rem_q, dvsr_q;
  logic             quo_neg_q, rem_neg_q;

  logic [DataW-1:0] mag1, mag2;
  logic [DataW-1:0] shifted;
  logic             ge;
  logic [DataW-1:0] quo_step, rem_step;

  always_comb begin
    mag1 = (signed_i && src1_i[DataW-1]) ? -src1_i : src1_i;
    mag2 = (signed_i && src2_i[DataW-1]) ? -src2_i : src2_i;
    // Partial remainder shifted left; its dropped MSB means it already exceeds the divisor.
    shifted  = {rem_q[DataW-2:0], quo_q[DataW-1]};
    ge       = rem_q[DataW-1] || (shifted >= dvsr_q);
    rem_step = ge ? (shifted - dvsr_q) : shifted;
    quo_step = {quo_q[DataW-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      state_q   <= DivIdle;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvsr_q    <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
    end else begin
      case (state_q)
        DivIdle: begin
          if (start_i) begin
            quo_neg_q <= signed_i && (src1_i[DataW-1] ^ src2_i[DataW-1]);
            rem_neg_q <= signed_i && src1_i[DataW-1];
            cnt_q     <= '0;
            quo_q     <= mag1;
            rem_q     <= '0;
            dvsr_q    <= mag2;
            state_q   <= (src2_i == zero_word) ? DivByZero : DivBusy;
          end
        end
        DivBusy: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            // Last step: store sign-corrected results for DONE.
            quo_q   <= quo_neg_q ? -quo_step : quo_step;
            rem_q   <= rem_neg_q ? -rem_step : rem_step;
            state_q <= DivDone;
          end else begin
            quo_q <= quo_step;
            rem_q <= rem_step;
          end
        end
        DivByZero: begin
          quo_q   <= '0;
          rem_q   <= '0;
          state_q <= DivDone;
        end
        DivDone: begin
          state_q <= DivIdle;
        end
        default: state_q <= DivIdle;
      endcase
    end
  end

  always_comb begin
    stall_o   = 1'b0;
    hilo_we_o = 1'b0;
    hi_o      = zero_word;
    lo_o      = zero_word;
    unique case (state_q)
      DivIdle:   stall_o = start_i && !flush_i;
      DivBusy:   stall_o = 1'b1;
      DivByZero: stall_o = 1'b1;
      DivDone: begin
        // A flush in the DONE cycle suppresses the HI/LO write.
        if (!flush_i) begin
          hilo_we_o = 1'b1;
          hi_o      = rem_q;
          lo_o      = quo_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage. Combinational logic/shift/arithmetic ALU feeding the EX/MEM
// register, plus an optional iterative divider writing HI/LO.
//   clk, rst : clock, synchronous active-high reset (all outputs 0 while rst=1)
//   bus      : ex_stage_if.slave -- ID/EX inputs, flush, EX/MEM outputs, stall_req
// Build option: define EX_DIV_EN to include the divider (div_unit). Without it, DIV/DIVU
// behave as NOPs and stall_req is tied low.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int unsigned DIV_STEPS = 32
) (
  input  logic       clk,
  input  logic       rst,
  ex_stage_if.slave  bus
);

  logic             is_div;
  logic [DataW-1:0] a, b;
  logic [DataW-1:0] sum, diff;
  logic [DataW-1:0] alu_res;
  logic             ovf;

  logic             div_stall;
  logic             div_we;
  logic [DataW-1:0] div_hi, div_lo;

  assign a      = bus.ex_src1;
  assign b      = bus.ex_src2;
  assign is_div = (bus.ex_alu_op == exe_div_op) || (bus.ex_alu_op == exe_divu_op);
  assign sum    = a + b;
  assign diff   = a - b;

  always_comb begin
    alu_res = zero_word;
    ovf     = 1'b0;
    case (bus.ex_alu_sel)
      RES_LOGIC: begin
        case (bus.ex_alu_op)
          exe_and_op: alu_res = a & b;
          exe_or_op:  alu_res = a | b;
          exe_xor_op: alu_res = a ^ b;
          exe_nor_op: alu_res = ~(a | b);
          default:    alu_res = zero_word;
        endcase
      end
      RES_SHIFT: begin
        case (bus.ex_alu_op)
          exe_sll_op: alu_res = b << a[4:0];
          exe_srl_op: alu_res = b >> a[4:0];
          exe_sra_op: alu_res = $signed(b) >>> a[4:0];
          default:    alu_res = zero_word;
        endcase
      end
      RES_ARITH: begin
        case (bus.ex_alu_op)
          exe_add_op: begin
            alu_res = sum;
            ovf     = (a[DataW-1] == b[DataW-1]) && (sum[DataW-1] != a[DataW-1]);
          end
          exe_addu_op: alu_res = sum;
          exe_sub_op: begin
            alu_res = diff;
            ovf     = (a[DataW-1] != b[DataW-1]) && (diff[DataW-1] != a[DataW-1]);
          end
          exe_subu_op: alu_res = diff;
          exe_slt_op:  alu_res = {{(DataW-1){1'b0}}, $signed(a) < $signed(b)};
          exe_sltu_op: alu_res = {{(DataW-1){1'b0}}, a < b};
          default:     alu_res = zero_word;
        endcase
      end
      default: alu_res = zero_word;
    endcase
  end

`ifdef EX_DIV_EN
  div_unit #(
    .DIV_STEPS (DIV_STEPS)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (bus.flush),
    .start_i   (is_div),
    .signed_i  (bus.ex_alu_op == exe_div_op),
    .src1_i    (a),
    .src2_i    (b),
    .stall_o   (div_stall),
    .hilo_we_o (div_we),
    .hi_o      (div_hi),
    .lo_o      (div_lo)
  );
`else
  logic unused_div;
  assign unused_div = ^{clk, bus.flush};
  assign div_stall  = 1'b0;
  assign div_we     = 1'b0;
  assign div_hi     = zero_word;
  assign div_lo     = zero_word;
`endif

  always_comb begin
    bus.em_result    = zero_word;
    bus.em_des_addr  = '0;
    bus.em_des_exist = 1'b0;
    bus.em_hi        = zero_word;
    bus.em_lo        = zero_word;
    bus.em_hilo_we   = 1'b0;
    bus.stall_req    = 1'b0;
    if (!rst) begin
      bus.em_result    = is_div ? zero_word : alu_res;
      bus.em_des_addr  = bus.ex_des_addr;
      bus.em_des_exist = bus.ex_des_exist && !ovf && !is_div;
      bus.em_hi        = div_hi;
      bus.em_lo        = div_lo;
      bus.em_hilo_we   = div_we;
      bus.stall_req    = div_stall;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ex_stage_if bus ();

  ex_stage #(
    .DIV_STEPS (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0]  op;
    logic [2:0]  sel;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [4:0]  addr;
    logic        dex;
    logic [31:0] res;
    logic        exist;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] s1,
                       input logic [31:0] s2, input logic [4:0] addr, input logic dex);
    bus.ex_alu_op    = op;
    bus.ex_alu_sel   = sel;
    bus.ex_src1      = s1;
    bus.ex_src2      = s2;
    bus.ex_des_addr  = addr;
    bus.ex_des_exist = dex;
  endtask

  task automatic set_nop();
    drive(8'h00, RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  // Called right at a negedge; returns at negedge+1 of the DONE cycle.
  task automatic run_div(input string name, input logic [7:0] op, input logic [31:0] s1,
                         input logic [31:0] s2, input int exp_n, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi);
    int n;
    n = 0;
    drive(op, RES_ARITH, s1, s2, 5'd3, 1'b1);
    #1;
    while (bus.stall_req && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    if (n >= 100) $display("FAIL %s: stall_req never dropped", name);
    check({name, " stall cycles"}, n, exp_n);
    check({name, " hilo_we"}, {31'b0, bus.em_hilo_we}, 32'h1);
    check({name, " lo"}, bus.em_lo, exp_lo);
    check({name, " hi"}, bus.em_hi, exp_hi);
    check({name, " des_exist"}, {31'b0, bus.em_des_exist}, 32'h0);
  endtask

  // Watch for a stray HI/LO write over a window of cycles.
  task automatic no_we_window(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      #1;
      if (bus.em_hilo_we || bus.stall_req) seen = 1'b1;
    end
    check(name, {31'b0, seen}, 32'h0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.flush = 1'b0;

    vecs[0]  = '{exe_add_op,  RES_ARITH, 32'h7FFFFFFF, 32'h00000001, 5'd1,  1'b1, 32'h80000000, 1'b0};
    vecs[1]  = '{exe_addu_op, RES_ARITH, 32'h7FFFFFFF, 32'h00000001, 5'd2,  1'b1, 32'h80000000, 1'b1};
    vecs[2]  = '{exe_sra_op,  RES_SHIFT, 32'h00000004, 32'h80000010, 5'd3,  1'b1, 32'hF8000001, 1'b1};
    vecs[3]  = '{exe_sltu_op, RES_ARITH, 32'h00000001, 32'hFFFFFFFF, 5'd4,  1'b1, 32'h00000001, 1'b1};
    vecs[4]  = '{exe_slt_op,  RES_ARITH, 32'h00000001, 32'hFFFFFFFF, 5'd5,  1'b1, 32'h00000000, 1'b1};
    vecs[5]  = '{exe_and_op,  RES_LOGIC, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd6,  1'b1, 32'h00F000F0, 1'b1};
    vecs[6]  = '{exe_or_op,   RES_LOGIC, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd7,  1'b1, 32'hFFF0FFF0, 1'b1};
    vecs[7]  = '{exe_xor_op,  RES_LOGIC, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd8,  1'b1, 32'hFF00FF00, 1'b1};
    vecs[8]  = '{exe_nor_op,  RES_LOGIC, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd9,  1'b1, 32'h000F000F, 1'b1};
    vecs[9]  = '{exe_sll_op,  RES_SHIFT, 32'h0000003F, 32'h00000001, 5'd10, 1'b1, 32'h80000000, 1'b1};
    vecs[10] = '{exe_srl_op,  RES_SHIFT, 32'h00000004, 32'h80000000, 5'd11, 1'b1, 32'h08000000, 1'b1};
    vecs[11] = '{exe_sub_op,  RES_ARITH, 32'h80000000, 32'h00000001, 5'd12, 1'b1, 32'h7FFFFFFF, 1'b0};
    vecs[12] = '{exe_subu_op, RES_ARITH, 32'h80000000, 32'h00000001, 5'd13, 1'b1, 32'h7FFFFFFF, 1'b1};
    vecs[13] = '{exe_sub_op,  RES_ARITH, 32'h00000005, 32'h00000007, 5'd14, 1'b1, 32'hFFFFFFFE, 1'b1};
    vecs[14] = '{exe_add_op,  RES_ARITH, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd15, 1'b1, 32'hFFFFFFFE, 1'b1};
    vecs[15] = '{exe_add_op,  RES_NOP,   32'h00000003, 32'h00000004, 5'd16, 1'b1, 32'h00000000, 1'b1};
    vecs[16] = '{exe_add_op,  3'b111,    32'h00000003, 32'h00000004, 5'd17, 1'b1, 32'h00000000, 1'b1};
    vecs[17] = '{exe_addu_op, RES_ARITH, 32'h00000003, 32'h00000004, 5'd31, 1'b0, 32'h00000007, 1'b0};

    // Reset: every output 0 even with a live ALU op on the inputs.
    rst = 1'b1;
    drive(exe_addu_op, RES_ARITH, 32'h1, 32'h2, 5'd7, 1'b1);
    #2;
    check("rst result", bus.em_result, 32'h0);
    check("rst des_addr", {27'b0, bus.em_des_addr}, 32'h0);
    check("rst des_exist", {31'b0, bus.em_des_exist}, 32'h0);
    check("rst hilo_we", {31'b0, bus.em_hilo_we}, 32'h0);
    check("rst hi", bus.em_hi, 32'h0);
    check("rst lo", bus.em_lo, 32'h0);
    check("rst stall", {31'b0, bus.stall_req}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].op, vecs[i].sel, vecs[i].s1, vecs[i].s2, vecs[i].addr, vecs[i].dex);
      #1;
      check($sformatf("vec%0d result", i), bus.em_result, vecs[i].res);
      check($sformatf("vec%0d des_exist", i), {31'b0, bus.em_des_exist}, {31'b0, vecs[i].exist});
      check($sformatf("vec%0d des_addr", i), {27'b0, bus.em_des_addr}, {27'b0, vecs[i].addr});
      check($sformatf("vec%0d stall", i), {31'b0, bus.stall_req}, 32'h0);
      check($sformatf("vec%0d hilo_we", i), {31'b0, bus.em_hilo_we}, 32'h0);
      @(negedge clk);
    end

`ifdef EX_DIV_EN
    run_div("div -7/2", exe_div_op, 32'hFFFFFFF9, 32'h00000002, 33, 32'hFFFFFFFD, 32'hFFFFFFFF);
    @(negedge clk);
    run_div("divu 100/7", exe_divu_op, 32'd100, 32'd7, 33, 32'd14, 32'd2);
    @(negedge clk);
    run_div("divu 9/3", exe_divu_op, 32'd9, 32'd3, 33, 32'd3, 32'd0);
    @(negedge clk);
    set_nop();
    #1;
    check("after done hilo_we", {31'b0, bus.em_hilo_we}, 32'h0);
    check("after done lo", bus.em_lo, 32'h0);
    @(negedge clk);
    run_div("div min/-1", exe_div_op, 32'h80000000, 32'hFFFFFFFF, 33, 32'h80000000, 32'h0);
    @(negedge clk);
    run_div("div 7/-2", exe_div_op, 32'h00000007, 32'hFFFFFFFE, 33, 32'hFFFFFFFD, 32'h1);
    @(negedge clk);
    run_div("div by zero", exe_div_op, 32'h00000005, 32'h0, 2, 32'h0, 32'h0);

    // Flush in BUSY cycle 10.
    @(negedge clk);
    drive(exe_divu_op, RES_ARITH, 32'd100, 32'd7, 5'd3, 1'b1);
    #1;
    check("flush detect stall", {31'b0, bus.stall_req}, 32'h1);
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    set_nop();
    #1;
    check("flush stall next", {31'b0, bus.stall_req}, 32'h0);
    check("flush hilo_we next", {31'b0, bus.em_hilo_we}, 32'h0);
    no_we_window("flush no write", 40);
    @(negedge clk);
    run_div("post-flush divu 9/3", exe_divu_op, 32'd9, 32'd3, 33, 32'd3, 32'd0);

    // Reset mid-divide.
    @(negedge clk);
    drive(exe_divu_op, RES_ARITH, 32'd100, 32'd7, 5'd3, 1'b1);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid rst stall", {31'b0, bus.stall_req}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    set_nop();
    #1;
    check("rst stall next", {31'b0, bus.stall_req}, 32'h0);
    no_we_window("rst no write", 40);
    @(negedge clk);
    run_div("post-rst divu 100/7", exe_divu_op, 32'd100, 32'd7, 33, 32'd14, 32'd2);
`else
    // Divider absent: DIV/DIVU behave as NOP.
    drive(exe_div_op, RES_ARITH, 32'hFFFFFFF9, 32'h2, 5'd3, 1'b1);
    #1;
    check("nodiv stall", {31'b0, bus.stall_req}, 32'h0);
    check("nodiv result", bus.em_result, 32'h0);
    check("nodiv des_exist", {31'b0, bus.em_des_exist}, 32'h0);
    no_we_window("nodiv no write", 40);
    drive(exe_divu_op, RES_ARITH, 32'd100, 32'd7, 5'd3, 1'b1);
    #1;
    check("nodivu result", bus.em_result, 32'h0);
    check("nodivu des_exist", {31'b0, bus.em_des_exist}, 32'h0);
`endif

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
